// File: rtl/ota_ctrl_pkg.sv
// Shared types and constants for the OTA offset-trim calibration controller.
package ota_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DECIDE,
    DONE
  } ota_state_e;

  localparam int unsigned CMP_VOTES      = 3;
  localparam int unsigned VOTE_MAJ       = 2;
  localparam int unsigned TRIM_W_DEF     = 6;
  localparam int unsigned SETTLE_CYC_DEF = 16;

endpackage

// File: rtl/ota_trim_cal_if.sv
// Control/status bus between the tile pin logic and the trim calibration controller.
interface ota_trim_cal_if
  import ota_ctrl_pkg::*;
#(
  parameter int unsigned TRIM_W = TRIM_W_DEF
);
  logic              ena;
  logic              start;
  logic              load_en;
  logic [TRIM_W-1:0] load_code;
  logic              busy;
  logic              done;
  logic              fail;

  modport master (
    output ena, start, load_en, load_code,
    input  busy, done, fail
  );

  modport slave (
    input  ena, start, load_en, load_code,
    output busy, done, fail
  );
endinterface

// File: rtl/ota_sync2.sv
// Two-flop synchronizer with asynchronous active-low reset to 0.
module ota_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/ota_trim_cal.sv
// OTA offset-trim calibration: SAR search over the trim code, each bit judged
// by a 3-sample majority vote of the synchronized comparator output.
module ota_trim_cal
  import ota_ctrl_pkg::*;
#(
  parameter int unsigned TRIM_W     = TRIM_W_DEF,
  parameter int unsigned SETTLE_CYC = SETTLE_CYC_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  ota_trim_cal_if.slave     ctl,
  input  logic              cmp_in,
  output logic [TRIM_W-1:0] trim_code,
  output logic              short_en
);
  localparam int unsigned IDX_W = (TRIM_W > 1) ? $clog2(TRIM_W) : 1;
  localparam int unsigned CNT_W = $clog2(SETTLE_CYC);
  localparam logic [TRIM_W-1:0] MID = {1'b1, {(TRIM_W-1){1'b0}}};
  localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(SETTLE_CYC - 1);

  ota_state_e        state_q, state_d;
  logic [TRIM_W-1:0] trim_q, trim_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        vote_q, vote_d;
  logic [1:0]        samp_q, samp_d;
  logic              short_q, short_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              fail_q, fail_d;
  logic              cmp_s;

  ota_sync2 u_cmp_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (cmp_in),
    .q     (cmp_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      trim_q  <= MID;
      idx_q   <= '0;
      cnt_q   <= '0;
      vote_q  <= '0;
      samp_q  <= '0;
      short_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      trim_q  <= trim_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      vote_q  <= vote_d;
      samp_q  <= samp_d;
      short_q <= short_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      fail_q  <= fail_d;
    end
  end

  // done/short_en/busy/fail are registered, so their DONE-state values are
  // loaded on the DECIDE->DONE edge and appear exactly in the DONE cycle.
  always_comb begin
    state_d = state_q;
    trim_d  = trim_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    vote_d  = vote_q;
    samp_d  = samp_q;
    short_d = short_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    fail_d  = fail_q;

    unique case (state_q)
      IDLE: begin
        if (ctl.start && ctl.ena) begin
          trim_d  = MID;
          idx_d   = IDX_W'(TRIM_W - 1);
          short_d = 1'b1;
          busy_d  = 1'b1;
          fail_d  = 1'b0;
          cnt_d   = CNT_INIT;
          state_d = SETTLE;
        end else if (ctl.load_en) begin
          trim_d = ctl.load_code;
        end
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          vote_d  = '0;
          samp_d  = '0;
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      SAMPLE: begin
        if (cmp_s && (vote_q != 2'd3)) vote_d = vote_q + 2'd1;
        if (samp_q == 2'(CMP_VOTES - 1)) state_d = DECIDE;
        else                             samp_d  = samp_q + 2'd1;
      end
      DECIDE: begin
        if (vote_q >= 2'(VOTE_MAJ)) trim_d[idx_q] = 1'b0;
        if (idx_q != '0) begin
          trim_d[idx_q - IDX_W'(1)] = 1'b1;
          idx_d   = idx_q - IDX_W'(1);
          cnt_d   = CNT_INIT;
          state_d = SETTLE;
        end else begin
          done_d  = 1'b1;
          short_d = 1'b0;
          busy_d  = 1'b0;
          fail_d  = (trim_d == '0) || (trim_d == '1);
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort keeps the partially searched code and the previous fail flag.
    if (!ctl.ena && (state_q != IDLE)) begin
      state_d = IDLE;
      trim_d  = trim_q;
      short_d = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      fail_d  = fail_q;
    end
  end

  assign trim_code = trim_q;
  assign short_en  = short_q;
  assign ctl.busy  = busy_q;
  assign ctl.done  = done_q;
  assign ctl.fail  = fail_q;
endmodule

// File: tb/tb_ota_trim_cal.sv
// Scoreboard bench for ota_trim_cal against a threshold comparator model.
module tb_ota_trim_cal;
  localparam int TW       = 6;
  localparam int SC       = 16;
  localparam int BIT_CYC  = SC + 4;
  localparam int DONE_CYC = TW * BIT_CYC + 1;
  localparam int MAXC     = (1 << TW) - 1;

  typedef struct {
    int code;
    int fail;
    int cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmp_in;
  logic [TW-1:0] trim_code;
  logic          short_en;
  logic          glitch;

  int   cyc = 0;
  int   thr = 0;
  int   st_cyc = 0;
  bit   glitch_en = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  ota_trim_cal_if #(.TRIM_W(TW)) ctl ();

  ota_trim_cal #(.TRIM_W(TW), .SETTLE_CYC(SC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ctl       (ctl),
    .cmp_in    (cmp_in),
    .trim_code (trim_code),
    .short_en  (short_en)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // One-cycle inverted glitch per bit, landing mid-way through the vote window.
  assign glitch = glitch_en && ((cyc - st_cyc) >= 1) && ((cyc - st_cyc) <= TW * BIT_CYC)
                  && (((cyc - st_cyc) % BIT_CYC) == SC);
  assign cmp_in = ((int'(trim_code) > thr) ? 1'b1 : 1'b0) ^ glitch;

  function automatic void check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Code after ndec SAR decisions, with the next trial bit already set.
  function automatic int sar_model(int t, int ndec);
    int code = 0;
    for (int b = TW - 1; b >= TW - ndec; b--) begin
      code = code | (1 << b);
      if (code > t) code = code & ~(1 << b);
    end
    if (ndec < TW) code = code | (1 << (TW - 1 - ndec));
    return code;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && ctl.done === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        check("final_code", int'(trim_code), e.code);
        check("final_fail", int'(ctl.fail), e.fail);
        check("done_cycle", cyc, e.cyc);
        check("short_en_at_done", int'(short_en), 0);
        check("busy_at_done", int'(ctl.busy), 0);
      end
    end
  end

  // Returns at the negedge inside cycle 1 of the calibration.
  task automatic start_cal(input int t, input bit g, input bit with_load);
    exp_t e;
    @(negedge clk);
    thr           = t;
    glitch_en     = g;
    st_cyc        = cyc;
    ctl.start     = 1'b1;
    ctl.load_en   = with_load;
    ctl.load_code = 6'h15;
    e.code = sar_model(t, TW);
    e.fail = (e.code == 0 || e.code == MAXC) ? 1 : 0;
    e.cyc  = st_cyc + DONE_CYC;
    sb.push_back(e);
    @(negedge clk);
    ctl.start   = 1'b0;
    ctl.load_en = 1'b0;
    check("start_code", int'(trim_code), 1 << (TW - 1));
    check("start_busy", int'(ctl.busy), 1);
    check("start_short_en", int'(short_en), 1);
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int n = 0; n < 3 * DONE_CYC; n++) begin
      @(negedge clk);
      if (sb.size() == 0) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      check("done_timeout", 1, 0);
      sb.delete();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_trim"}, int'(trim_code), 1 << (TW - 1));
    check({tag, "_short_en"}, int'(short_en), 0);
    check({tag, "_busy"}, int'(ctl.busy), 0);
    check({tag, "_done"}, int'(ctl.done), 0);
    check({tag, "_fail"}, int'(ctl.fail), 0);
  endtask

  initial begin
    int t;
    rst_n         = 1'b0;
    ctl.ena       = 1'b1;
    ctl.start     = 1'b0;
    ctl.load_en   = 1'b0;
    ctl.load_code = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Nominal threshold, with short_en/busy probed just before completion.
    start_cal(37, 1'b0, 1'b0);
    repeat (DONE_CYC - 2) @(negedge clk);
    check("short_en_last_cycle", int'(short_en), 1);
    check("busy_last_cycle", int'(ctl.busy), 1);
    check("done_early", int'(ctl.done), 0);
    wait_done();

    start_cal(MAXC, 1'b0, 1'b0); wait_done();
    start_cal(0, 1'b0, 1'b0);    wait_done();
    start_cal(37, 1'b1, 1'b0);   wait_done();

    // Manual load in IDLE.
    @(negedge clk);
    ctl.load_en   = 1'b1;
    ctl.load_code = 6'h2A;
    @(negedge clk);
    ctl.load_en = 1'b0;
    check("idle_load", int'(trim_code), 'h2A);

    // Load while busy is ignored.
    start_cal(37, 1'b0, 1'b0);
    repeat (BIT_CYC + 9) @(negedge clk);
    ctl.load_en   = 1'b1;
    ctl.load_code = '0;
    @(negedge clk);
    ctl.load_en = 1'b0;
    check("busy_load_ignored", int'(trim_code), sar_model(37, 1));
    wait_done();

    // start wins over load_en (start_code checked inside start_cal).
    start_cal(20, 1'b0, 1'b1); wait_done();

    // Asynchronous reset in cycle 50.
    start_cal(45, 1'b0, 1'b0);
    repeat (49) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midcal_reset");
    void'(sb.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    repeat (DONE_CYC + 20) @(negedge clk);

    // ena dropped in cycle 50.
    start_cal(11, 1'b0, 1'b0);
    repeat (49) @(negedge clk);
    ctl.ena = 1'b0;
    void'(sb.pop_back());
    @(negedge clk);
    check("abort_busy", int'(ctl.busy), 0);
    check("abort_short_en", int'(short_en), 0);
    check("abort_partial_code", int'(trim_code), sar_model(11, 50 / BIT_CYC));
    check("abort_fail", int'(ctl.fail), 0);
    ctl.ena = 1'b1;
    repeat (DONE_CYC + 20) @(negedge clk);
    check("abort_code_held", int'(trim_code), sar_model(11, 50 / BIT_CYC));

    // Randomized thresholds and glitch injection.
    for (int i = 0; i < 10; i++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      t = int'($urandom_range(0, MAXC));
      start_cal(t, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      wait_done();
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
